// File: rtl/ram_3d_stream_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ram_3d_stream_reader
// Description : Lock-step port-B reader for a multi-bank feature RAM that
//               emits one RAM_NUM-lane word per beat on a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_3d_stream_reader #(
    parameter int RAM_NUM = 3,
    parameter int WIDTH   = 16,
    parameter int ADDRESS = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDRESS-1:0]  base_addr,
    input  logic [ADDRESS:0]    count,
    output logic                busy,
    output logic                done,
    output logic [RAM_NUM-1:0]  enb,
    output logic [RAM_NUM-1:0]  web,
    output logic [ADDRESS-1:0]  addrb [0:RAM_NUM-1],
    input  logic [WIDTH-1:0]    doutb [0:RAM_NUM-1],
    output logic                m_valid,
    input  logic                m_ready,
    output logic [WIDTH-1:0]    m_data [0:RAM_NUM-1],
    output logic                m_last
);

    localparam int LW = RAM_NUM * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               state_q;
    logic [ADDRESS-1:0]   base_q;
    logic [ADDRESS:0]     count_q;
    logic [ADDRESS:0]     issued_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 inflight_q;
    logic                 inflight_last_q;

    logic [LW-1:0]        fifo_data_q [0:1];
    logic [1:0]           fifo_last_q;
    logic                 rd_ptr_q;
    logic                 wr_ptr_q;
    logic [1:0]           occ_q;

    logic                 w_pop;
    logic                 w_push;
    logic [2:0]           w_outstanding;
    logic                 w_credit_ok;
    logic                 w_issue;
    logic                 w_last_issue;
    logic [ADDRESS-1:0]   w_addr;
    logic [LW-1:0]        w_dout_flat;
    logic [LW-1:0]        w_head;

    assign m_valid = (occ_q != 2'd0);
    assign w_pop   = m_valid & m_ready;
    assign w_push  = inflight_q;

    // Words already owed to the FIFO (stored + in flight) may not exceed its depth.
    assign w_outstanding = {1'b0, occ_q} + {2'b00, inflight_q};
    assign w_credit_ok   = (w_outstanding - {2'b00, w_pop}) < 3'd2;
    assign w_issue       = (state_q == S_RUN) && (issued_q < count_q) && w_credit_ok;
    assign w_last_issue  = (issued_q == (count_q - {{ADDRESS{1'b0}}, 1'b1}));
    assign w_addr        = base_q + issued_q[ADDRESS-1:0];

    assign enb    = {RAM_NUM{w_issue}};
    assign web    = '0;
    assign busy   = busy_q;
    assign done   = done_q;
    assign w_head = fifo_data_q[rd_ptr_q];
    assign m_last = fifo_last_q[rd_ptr_q] & m_valid;

    generate
        for (genvar gi = 0; gi < RAM_NUM; gi++) begin : g_lane
            assign addrb[gi]                     = w_addr;
            assign w_dout_flat[gi*WIDTH +: WIDTH] = doutb[gi];
            assign m_data[gi]                    = w_head[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            base_q          <= '0;
            count_q         <= '0;
            issued_q        <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            done_q          <= 1'b0;
            inflight_q      <= w_issue;
            inflight_last_q <= w_issue & w_last_issue;
            if (w_issue) begin
                issued_q <= issued_q + {{ADDRESS{1'b0}}, 1'b1};
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            base_q   <= base_addr;
                            count_q  <= count;
                            issued_q <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (issued_q == count_q) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    state_q <= S_DRAIN;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            // The final beat leaving implies the FIFO is empty and nothing is in flight.
            if ((state_q != S_IDLE) && w_pop && m_last) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
            end
            fifo_last_q <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            occ_q       <= '0;
        end else begin
            if (w_push) begin
                fifo_data_q[wr_ptr_q] <= w_dout_flat;
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_3d_stream_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ram_3d_stream_reader
// Description : Scoreboard bench for ram_3d_stream_reader with a banked RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_3d_stream_reader;

    localparam int RN    = 3;
    localparam int W     = 16;
    localparam int A     = 12;
    localparam int DEPTH = 1 << A;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [A-1:0]     base_addr;
    logic [A:0]       count;
    logic             busy;
    logic             done;
    logic [RN-1:0]    enb;
    logic [RN-1:0]    web;
    logic [A-1:0]     addrb [0:RN-1];
    logic [W-1:0]     doutb [0:RN-1];
    logic             m_valid;
    logic             m_ready;
    logic [W-1:0]     m_data [0:RN-1];
    logic             m_last;

    ram_3d_stream_reader #(.RAM_NUM(RN), .WIDTH(W), .ADDRESS(A)) u_dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .busy(busy), .done(done), .enb(enb), .web(web), .addrb(addrb), .doutb(doutb),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] word(input int bank, input int a);
        return W'(bank * 256 + a);
    endfunction

    function automatic logic [RN*W-1:0] beat_word(input int a);
        logic [RN*W-1:0] v;
        for (int i = 0; i < RN; i++) v[i*W +: W] = word(i, a);
        return v;
    endfunction

    // Banked RAM with one-cycle registered read on port B
    logic [W-1:0] mem [0:RN-1][0:DEPTH-1];
    initial begin
        for (int b = 0; b < RN; b++)
            for (int a = 0; a < DEPTH; a++) mem[b][a] = word(b, a);
    end
    always @(posedge clk) begin
        for (int i = 0; i < RN; i++)
            if (enb[i] && !web[i]) doutb[i] <= mem[i][addrb[i]];
    end

    int rmode  = 0;
    int pat_idx = 0;
    bit pat [0:7] = '{1, 0, 0, 1, 0, 1, 1, 0};
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       m_ready = 1'b1;
                1:       begin m_ready = pat[pat_idx % 8]; pat_idx++; end
                default: m_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    typedef struct {
        logic [RN*W-1:0] data;
        logic            last;
    } beat_t;

    beat_t       exp_q [$];
    int unsigned addr_q [$];
    bit          exp_busy    = 0;
    bit          zero_flag   = 0;
    bit          last_hs_prev = 0;
    bit          stall_prev  = 0;
    int          outstanding = 0;
    int          hs_total    = 0;
    logic [RN*W-1:0] held_data;
    logic        held_last;

    logic [RN*W-1:0] mon_ad;
    beat_t       mon_b;
    bit          mon_hs;
    bit          mon_expd;
    int unsigned mon_ea;

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            mon_ad   = {m_data[2], m_data[1], m_data[0]};
            mon_hs   = m_valid && m_ready;
            mon_expd = last_hs_prev || zero_flag;
            if (done || mon_expd) chk("done_pulse", done, mon_expd);
            zero_flag = 0;
            if (mon_expd) exp_busy = 0;
            chk("busy", busy, exp_busy);
            last_hs_prev = 0;
            if (enb != '0) begin
                chk("enb_all_lanes", enb, {RN{1'b1}});
                chk("web_zero", web, 0);
                chk("credit", (outstanding + 1 - int'(mon_hs)) <= 2, 1);
                if (addr_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_read actual=enb=%0h required=no_read at %0t", enb, $time);
                end else begin
                    mon_ea = addr_q.pop_front();
                    for (int i = 0; i < RN; i++) chk("addrb", addrb[i], mon_ea);
                end
            end
            if (m_valid && exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL spurious_beat actual=m_valid=1 required=0 at %0t", $time);
            end
            if (stall_prev) begin
                chk("stall_data", mon_ad, held_data);
                chk("stall_last", m_last, held_last);
            end
            if (mon_hs && exp_q.size() > 0) begin
                mon_b = exp_q.pop_front();
                chk("beat_data", mon_ad, mon_b.data);
                chk("beat_last", m_last, mon_b.last);
                last_hs_prev = mon_b.last;
                hs_total++;
            end
            stall_prev  = m_valid && !m_ready;
            held_data   = mon_ad;
            held_last   = m_last;
            outstanding += ((enb != '0) ? 1 : 0) - (mon_hs ? 1 : 0);
        end
    end

    task automatic issue_start(input int b, input int c);
        @(posedge clk);
        #1;
        base_addr = A'(b);
        count     = (A+1)'(c);
        start     = 1'b1;
        for (int k = 0; k < c; k++) begin
            beat_t e;
            e.data = beat_word((b + k) % DEPTH);
            e.last = (k == c - 1);
            exp_q.push_back(e);
            addr_q.push_back((b + k) % DEPTH);
        end
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = A'($urandom);
        count     = (A+1)'($urandom);
        if (c == 0) zero_flag = 1;
        else        exp_busy  = 1;
    endtask

    task automatic run_xfer(input int b, input int c, input int mode, input bit timing, input bit mid_start);
        int first_v = 0;
        int last_c  = 0;
        int done_c  = 0;
        rmode   = mode;
        pat_idx = 0;
        issue_start(b, c);
        for (int cyc = 1; cyc <= c * 12 + 40; cyc++) begin
            @(negedge clk);
            if (m_valid && first_v == 0) first_v = cyc;
            if (m_valid && m_ready && m_last) last_c = cyc;
            if (done) begin done_c = cyc; break; end
            if (mid_start && cyc == 4) begin
                #1;
                start     = 1'b1;
                base_addr = A'($urandom);
                count     = (A+1)'(5);
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        if (done_c == 0) begin
            checks++; failures++;
            $display("FAIL done_timeout actual=no_done required=done base=%0d count=%0d", b, c);
        end else if (timing) begin
            if (c > 0) begin
                chk("first_valid_cycle", first_v, 3);
                chk("last_beat_cycle", last_c, c + 2);
                chk("done_cycle", done_c, c + 3);
            end else begin
                chk("done_cycle_zero", done_c, 1);
            end
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_enb"}, enb, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_addrb"}, {addrb[2], addrb[1], addrb[0]}, 0);
        chk({tag, "_m_data"}, {m_data[2], m_data[1], m_data[0]}, 0);
    endtask

    task automatic reset_mid_transfer();
        int h0;
        bit seen = 0;
        rmode = 0;
        h0 = hs_total;
        issue_start(300, 10);
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            if (hs_total >= h0 + 2) begin seen = 1; break; end
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL reset_wait actual=beats_%0d required=2", hs_total - h0);
        end
        #1;
        rst = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        exp_q.delete();
        addr_q.delete();
        exp_busy     = 0;
        zero_flag    = 0;
        last_hs_prev = 0;
        stall_prev   = 0;
        outstanding  = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (6) @(posedge clk);
        run_xfer(0, 2, 0, 1, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        count     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b1;
        repeat (2) @(posedge clk);

        run_xfer(0, 4, 0, 1, 0);
        run_xfer(4094, 4, 0, 1, 0);
        run_xfer(100, 8, 1, 0, 0);
        run_xfer(7, 0, 0, 1, 0);
        run_xfer(200, 8, 0, 1, 1);
        run_xfer(4095, 1, 0, 1, 0);
        reset_mid_transfer();
        run_xfer(123, 4096, 0, 1, 0);
        for (int t = 0; t < 20; t++) begin
            int m;
            m = $urandom_range(0, 2);
            run_xfer($urandom_range(0, DEPTH - 1), $urandom_range(1, 40), m, (m == 0), 0);
        end
        if (exp_q.size() != 0 || addr_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL leftover_expectations actual=%0d required=0", exp_q.size() + addr_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
